bennett_sequencer: RTL
======================

# bennett_sequencer

Upstream control stage for the adiabatic datapath blocks such as the 16-bit AND. It accepts one operand pair per transaction through a valid/ready handshake and holds the operands stable on the datapath inputs. It drives a full Bennett clock cycle (ramp each level up in order, hold, ramp down in reverse), captures the datapath result at the plateau, and presents it through a valid/ready output. It replaces bench-side operand poking with a cycle-exact, backpressure-aware front end.

## Interface
Parameters:
- DATA_W, 16, operand and result width.
- LEVELS, 2, number of clkp/clkn phase pairs (datapath logic depth). Must be ≥1.
- HOLD_CYCLES, 1, plateau cycles with all levels high before capture. Must be ≥1.

Ports:
- clk  in  1  system clock; all state is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- op_a  out  DATA_W  registered operand A driven to the datapath.
- op_b  out  DATA_W  registered operand B driven to the datapath.
- clkp  out  LEVELS  per-level positive phase; bit k powers level k.
- clkn  out  LEVELS  per-level negative phase; always the bitwise inverse of clkp.
- dp_out  in  DATA_W  datapath result.
- out_valid  out  1  captured result is available.
- out_ready  in  1  consumer takes the result.
- out_data  out  DATA_W  captured result.
- instFlag  out  1  one-cycle pulse when a Bennett cycle fully completes.

## Operation
- FSM states: IDLE, RISE, HOLD, FALL.
- in_ready is combinational: (state==IDLE) && (!out_valid || out_ready).
- IDLE:
  - On the accept edge (in_valid && in_ready): load op_a/op_b, set level counter k=0, go to RISE.
  - op_a/op_b change only on an accept edge; they hold their value otherwise, including after the cycle ends.
- RISE: each edge sets clkp[k]=1 and increments k. After the edge that sets clkp[LEVELS-1], go to HOLD.
- HOLD:
  - Counts HOLD_CYCLES edges.
  - On the last HOLD edge: out_data<=dp_out, out_valid<=1, k=LEVELS-1, go to FALL.
- FALL: each edge clears clkp[k] and decrements k.
  - The edge that clears clkp[0] also sets instFlag=1 for exactly one cycle and returns to IDLE.
- Output handshake:
  - out_valid clears on an edge where out_ready=1, unless a capture occurs on the same edge.
  - out_data is stable while out_valid=1.
- clkp levels only ever change one bit per edge: monotonic up in index order, then down in reverse order.
- No capture can ever be lost. Acceptance requires the output slot to be free or draining, and capture occurs ≥LEVELS+1 edges later.

## Timing
- All outputs are registered except in_ready.
- Reset values:
  - state IDLE, k=0.
  - clkp=0, clkn=all ones.
  - op_a=op_b=0.
  - out_valid=0, out_data=0, instFlag=0.
  - in_ready=0 while reset is asserted; 1 after reset release.
- Transaction timeline, with accept at edge E0:
  - clkp[k] rises at E(1+k).
  - Capture and out_valid at E(LEVELS+HOLD_CYCLES).
  - clkp[k] falls at E(LEVELS+HOLD_CYCLES+LEVELS-k).
  - instFlag is high in the cycle after E(2·LEVELS+HOLD_CYCLES).
- Minimum accept-to-accept spacing: 2·LEVELS+HOLD_CYCLES+1 cycles. For the defaults this is 6.
- Accept-to-out_valid latency: LEVELS+HOLD_CYCLES edges. For the defaults this is 3.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronous), including an abrupt drop of every clkp.
  - Any pending result is discarded.
  - No instFlag pulse.
- Inputs changing while the sequencer is busy have no effect.

## Test plan
Defaults apply (DATA_W=16, LEVELS=2, HOLD_CYCLES=1). The bench models dp_out = op_a & op_b, valid only while all clkp are high, X otherwise.

- Reset: hold reset low, then release. Required: clkp=00, clkn=11, out_valid=0, instFlag=0, op_a=op_b=0000, and in_ready=1 on the first cycle after release.
- Single transaction: in_a=FFFF, in_b=0F0F, out_ready=1. Required, edge by edge from E1 to E5:
  - clkp sequence 01, 11, 11, 01, 00.
  - out_valid=1 with out_data=0F0F after E3.
  - instFlag pulse after E5.
- Back-to-back: in_valid held high across pairs (FFFF,0000), (0000,FFFF), (FFFF,FFFF), (0000,0000). Required:
  - Accepts are exactly 6 cycles apart.
  - Results are 0000, 0000, FFFF, 0000 in order.
  - 4 instFlag pulses.
- Backpressure: out_ready=0 after the first result (AAAA&FFFF). Required:
  - out_data=AAAA held.
  - in_ready stays 0 after the cycle completes.
  - Raising out_ready for one cycle lets the next pair be accepted in that same cycle.
- Operand stability: change in_a/in_b every cycle while busy. Required: op_a/op_b stay at the accepted values from E0 through the instFlag pulse.
- Reset mid-HOLD: assert reset between E2 and E3. Required:
  - clkp=00 and out_valid=0 immediately.
  - No instFlag pulse.
  - The next transaction after release behaves as in the single-transaction scenario.

Source files
------------

// File: rtl/bennett_sequencer.sv
// Bennett-clock front end for adiabatic datapaths: accepts an operand pair, ramps
// the phase levels up in order, captures the result at the plateau, then ramps down.
module bennett_sequencer #(
    parameter int DATA_W      = 16,
    parameter int LEVELS      = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [LEVELS-1:0] clkp,
    output logic [LEVELS-1:0] clkn,
    input  logic [DATA_W-1:0] dp_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              instFlag
);
    localparam int KW = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(LEVELS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic [LEVELS-1:0]   clkp_q, clkp_d;
    logic [LEVELS-1:0]   clkn_q, clkn_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                flag_q, flag_d;
    logic                accept;

    // Only accept when the result slot is free or draining this edge, so the
    // capture several edges later can never overwrite an unread result.
    assign in_ready = reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        hcnt_d      = hcnt_q;
        clkp_d      = clkp_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        flag_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d  = in_a;
                    op_b_d  = in_b;
                    k_d     = '0;
                    state_d = RISE;
                end
            end
            RISE: begin
                clkp_d[k_q] = 1'b1;
                if (k_q == K_LAST) begin
                    hcnt_d  = '0;
                    state_d = HOLD;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            HOLD: begin
                if (hcnt_q == H_LAST) begin
                    out_data_d  = dp_out;
                    out_valid_d = 1'b1;
                    k_d         = K_LAST;
                    state_d     = FALL;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            FALL: begin
                clkp_d[k_q] = 1'b0;
                if (k_q == '0) begin
                    flag_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        clkn_d = ~clkp_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            hcnt_q      <= '0;
            clkp_q      <= '0;
            clkn_q      <= '1;
            op_a_q      <= '0;
            op_b_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            hcnt_q      <= hcnt_d;
            clkp_q      <= clkp_d;
            clkn_q      <= clkn_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            flag_q      <= flag_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign clkp      = clkp_q;
    assign clkn      = clkn_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign instFlag  = flag_q;
endmodule
